// File: rtl/multicycle_control_fsm_pkg.sv
// -----------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared constants for the multi-cycle RV32I control path:
//   - RV32I major opcodes recognised by the sequencer
//   - ALUOp, ALU B-source and writeback-source encodings driven to the datapath
//   - FSM state encodings (plain 4-bit constants so older tools and
//     hand-written netlists can compare against them directly)
// No ports; imported by the controller, its interface and its sub-modules.
// -----------------------------------------------------------------------------
package rv_ctrl_pkg;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALU operation class; the ALU control block refines 10/11 using funct3/7
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_RTYPE = 2'b10,
    ALU_ITYPE = 2'b11
  } alu_op_e;

  // ALU B operand select
  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10
  } alu_src_b_e;

  // Register-file writeback source
  typedef enum logic [1:0] {
    WB_ALUOUT = 2'b00,
    WB_MDR    = 2'b01,
    WB_PC     = 2'b10
  } mem_to_reg_e;

  // FSM state encodings
  typedef logic [3:0] state_t;

  localparam state_t ST_FETCH    = 4'd0;
  localparam state_t ST_DECODE   = 4'd1;
  localparam state_t ST_EXEC_R   = 4'd2;
  localparam state_t ST_EXEC_I   = 4'd3;
  localparam state_t ST_ALU_WB   = 4'd4;
  localparam state_t ST_MEM_ADDR = 4'd5;
  localparam state_t ST_MEM_RD   = 4'd6;
  localparam state_t ST_MEM_WB   = 4'd7;
  localparam state_t ST_MEM_WR   = 4'd8;
  localparam state_t ST_BRANCH   = 4'd9;
  localparam state_t ST_JAL      = 4'd10;
  localparam state_t ST_TRAP     = 4'd11;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm_if
// Memory-port handshake between the multi-cycle controller and the shared
// instruction/data memory.
//   mem_req   : request, held stable until mem_ready
//   mem_we    : write strobe, qualified by mem_req
//   i_or_d    : address select (0 = PC, 1 = ALUOut), qualified by mem_req
//   mem_ready : memory completes the current request this cycle
// Modports: master = controller side, slave = memory side.
// -----------------------------------------------------------------------------
interface multicycle_control_fsm_if;

  logic mem_req;
  logic mem_we;
  logic i_or_d;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output i_or_d,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  i_or_d,
    output mem_ready
  );

endinterface

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Watchdog for the memory handshake. Counts cycles in which a request is
// outstanding without mem_ready and flags the cycle in which the count would
// reach MEM_TIMEOUT, so the controller leaves a memory state after exactly
// MEM_TIMEOUT unanswered request cycles.
// Ports:
//   clk      : core clock
//   rst_n    : asynchronous active-low reset, clears the count
//   clear    : restart the count (controller is entering a new state)
//   count_en : a request is outstanding and mem_ready is low this cycle
//   expired  : this is the MEM_TIMEOUT-th unanswered cycle; abort the request
// -----------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MEM_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Saturate rather than wrap so a stuck request can never look fresh again.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && (count_q != CNT_MAX)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_en already implies mem_ready is low, so a late mem_ready in the
  // expiry cycle suppresses the abort.
  assign expired = count_en && (count_q == CNT_LAST);

endmodule

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
// Main control sequencer for a multi-cycle RV32I datapath with one shared ALU
// and one shared memory port. Each instruction walks FETCH -> DECODE -> a
// class-specific path and returns to FETCH; instr_done marks the final cycle.
// Outputs decode from the registered state; the only input-dependent outputs
// are the handshake completions (ir_write/pc_write in FETCH, instr_done in
// MEM_WR), which fire in the cycle mem_ready is seen.
// Ports:
//   clk, rst_n      : core clock, asynchronous active-low reset
//   opcode          : instr[6:0] from the IR, used from DECODE onward
//   zero            : ALU zero flag (consumed by the datapath PC enable)
//   mem             : memory handshake (master side)
//   ir_write        : load instruction register
//   pc_write        : unconditional PC load
//   pc_write_cond   : PC load gated by zero in the datapath
//   pc_src          : 0 = ALU result, 1 = ALUOut
//   alu_src_a       : 0 = PC, 1 = rs1
//   alu_src_b       : 00 = rs2, 01 = 4, 10 = imm
//   alu_op          : 00 add, 01 sub, 10 R funct, 11 I funct
//   reg_write       : register file write
//   mem_to_reg      : 00 = ALUOut, 01 = MDR, 10 = PC (link)
//   illegal_op      : one-cycle pulse for an unsupported opcode
//   mem_timeout     : one-cycle pulse after a watchdog abort
//   instr_done      : one-cycle pulse in the last cycle of an instruction
// -----------------------------------------------------------------------------
module multicycle_control_fsm
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter bit ENABLE_JAL  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [6:0]               opcode,
  input  logic                     zero,
  multicycle_control_fsm_if.master mem,
  output logic                     ir_write,
  output logic                     pc_write,
  output logic                     pc_write_cond,
  output logic                     pc_src,
  output logic                     alu_src_a,
  output logic [1:0]               alu_src_b,
  output logic [1:0]               alu_op,
  output logic                     reg_write,
  output logic [1:0]               mem_to_reg,
  output logic                     illegal_op,
  output logic                     mem_timeout,
  output logic                     instr_done
);

  state_t state_q;
  state_t state_d;

  // Records why TRAP was entered so a single TRAP state can report either
  // an illegal opcode or a watchdog abort.
  logic trap_tmo_q;
  logic trap_tmo_d;

  logic mem_req_w;
  logic mem_we_w;
  logic i_or_d_w;
  logic wait_cycle;
  logic wd_clear;
  logic wd_expired;

  // Branch resolution happens in the datapath (pc_write | pc_write_cond & zero);
  // the sequence itself does not depend on the flag.
  logic unused_zero;
  assign unused_zero = zero;

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  assign wait_cycle = mem_req_w && !mem.mem_ready;
  // Any state change restarts the count, which covers entry into every
  // memory state (including FETCH after TRAP).
  assign wd_clear   = (state_d != state_q);

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (wd_clear),
    .count_en (wait_cycle),
    .expired  (wd_expired)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    trap_tmo_d = trap_tmo_q;

    case (state_q)
      ST_FETCH: begin
        if (mem.mem_ready) begin
          state_d = ST_DECODE;
        end else if (wd_expired) begin
          state_d    = ST_TRAP;
          trap_tmo_d = 1'b1;
        end
      end

      ST_DECODE: begin
        case (opcode)
          OP_LOAD,
          OP_STORE:  state_d = ST_MEM_ADDR;
          OP_REG:    state_d = ST_EXEC_R;
          OP_IMM:    state_d = ST_EXEC_I;
          OP_BRANCH: state_d = ST_BRANCH;
          OP_JAL: begin
            if (ENABLE_JAL) begin
              state_d = ST_JAL;
            end else begin
              state_d    = ST_TRAP;
              trap_tmo_d = 1'b0;
            end
          end
          default: begin
            state_d    = ST_TRAP;
            trap_tmo_d = 1'b0;
          end
        endcase
      end

      ST_EXEC_R,
      ST_EXEC_I:   state_d = ST_ALU_WB;

      ST_MEM_ADDR: state_d = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;

      ST_MEM_RD: begin
        if (mem.mem_ready) begin
          state_d = ST_MEM_WB;
        end else if (wd_expired) begin
          state_d    = ST_TRAP;
          trap_tmo_d = 1'b1;
        end
      end

      ST_MEM_WR: begin
        if (mem.mem_ready) begin
          state_d = ST_FETCH;
        end else if (wd_expired) begin
          state_d    = ST_TRAP;
          trap_tmo_d = 1'b1;
        end
      end

      ST_ALU_WB,
      ST_MEM_WB,
      ST_BRANCH,
      ST_JAL,
      ST_TRAP:     state_d = ST_FETCH;

      default:     state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FETCH;
      trap_tmo_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      trap_tmo_q <= trap_tmo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_req_w     = 1'b0;
    mem_we_w      = 1'b0;
    i_or_d_w      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALU_ADD;
    reg_write     = 1'b0;
    mem_to_reg    = WB_ALUOUT;
    illegal_op    = 1'b0;
    mem_timeout   = 1'b0;
    instr_done    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        // PC + 4 computed while the instruction is read; both loads commit
        // together in the completing cycle.
        mem_req_w = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem.mem_ready;
        pc_write  = mem.mem_ready;
      end

      ST_DECODE: begin
        // Speculative branch target (PC already +4 here) into ALUOut.
        alu_src_b = SRCB_IMM;
      end

      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALU_RTYPE;
      end

      ST_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ITYPE;
      end

      ST_ALU_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = WB_ALUOUT;
        instr_done = 1'b1;
      end

      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end

      ST_MEM_RD: begin
        mem_req_w = 1'b1;
        i_or_d_w  = 1'b1;
      end

      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = WB_MDR;
        instr_done = 1'b1;
      end

      ST_MEM_WR: begin
        mem_req_w  = 1'b1;
        mem_we_w   = 1'b1;
        i_or_d_w   = 1'b1;
        instr_done = mem.mem_ready;
      end

      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = 1'b1;
        instr_done    = 1'b1;
      end

      ST_JAL: begin
        // Link value is the already-incremented PC; target sits in ALUOut.
        reg_write  = 1'b1;
        mem_to_reg = WB_PC;
        pc_write   = 1'b1;
        pc_src     = 1'b1;
        instr_done = 1'b1;
      end

      ST_TRAP: begin
        illegal_op  = !trap_tmo_q;
        mem_timeout = trap_tmo_q;
        instr_done  = 1'b1;
      end

      default: ;
    endcase
  end

  assign mem.mem_req = mem_req_w;
  assign mem.mem_we  = mem_we_w;
  assign mem.i_or_d  = i_or_d_w;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
// Two controller instances: d0 (MEM_TIMEOUT = 3, JAL enabled) and
// d1 (MEM_TIMEOUT = 15, JAL disabled). For every instruction the reference
// model expands the instruction class and the chosen memory wait counts into
// a per-cycle schedule of (mem_ready to drive, opcode to drive, expected
// outputs); the bench replays it and compares every cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [6:0]  opcode_s    [2];
  logic        zero_s      [2];
  logic        mem_ready_s [2];
  logic [17:0] outv        [2];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rdy;
    logic [6:0]  opc;
    logic [17:0] exp;
  } cyc_t;

  cyc_t sched[$];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    multicycle_control_fsm_if mif ();
    logic       ir_write, pc_write, pc_write_cond, pc_src, alu_src_a;
    logic       reg_write, illegal_op, mem_timeout, instr_done;
    logic [1:0] alu_src_b, alu_op, mem_to_reg;

    multicycle_control_fsm #(
      .MEM_TIMEOUT ((gi == 0) ? 3 : 15),
      .ENABLE_JAL  (gi == 0)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .opcode        (opcode_s[gi]),
      .zero          (zero_s[gi]),
      .mem           (mif),
      .ir_write      (ir_write),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .pc_src        (pc_src),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op        (alu_op),
      .reg_write     (reg_write),
      .mem_to_reg    (mem_to_reg),
      .illegal_op    (illegal_op),
      .mem_timeout   (mem_timeout),
      .instr_done    (instr_done)
    );

    assign mif.mem_ready = mem_ready_s[gi];
    assign outv[gi] = {mif.mem_req, mif.mem_we, mif.i_or_d, ir_write, pc_write,
                       pc_write_cond, pc_src, alu_src_a, alu_src_b, alu_op,
                       reg_write, mem_to_reg, illegal_op, mem_timeout, instr_done};
  end

  task automatic check_eq(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end
  endtask

  // Output vector in outv bit order.
  function automatic logic [17:0] ov(input logic req, we, iod, irw, pcw, pcwc, pcs, asa,
                                     input logic [1:0] asb, aop,
                                     input logic rw,
                                     input logic [1:0] m2r,
                                     input logic ill, tmo, done);
    return {req, we, iod, irw, pcw, pcwc, pcs, asa, asb, aop, rw, m2r, ill, tmo, done};
  endfunction

  task automatic push(input logic r, input logic [6:0] o, input logic [17:0] e);
    cyc_t c;
    c.rdy = r;
    c.opc = o;
    c.exp = e;
    sched.push_back(c);
  endtask

  // A memory access that waits w cycles before mem_ready; gives up after
  // tmo unanswered cycles.
  task automatic mem_phase(input logic [17:0] base, input logic [17:0] on_ready,
                           input int w, input int tmo, input logic [6:0] opc,
                           output bit timed_out);
    int n;
    n = (w < tmo) ? w + 1 : tmo;
    for (int i = 0; i < n; i++) begin
      push(i == w, opc, (i == w) ? (base | on_ready) : base);
    end
    timed_out = (w >= tmo);
  endtask

  task automatic build(input int d, input logic [6:0] op, input int wf, input int wm);
    int          tmo;
    bit          jal_en;
    bit          to;
    logic [17:0] trap_tmo, trap_ill, mem_addr, alu_wb;
    tmo      = (d == 0) ? 3 : 15;
    jal_en   = (d == 0);
    trap_tmo = ov(0,0,0,0,0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 0,1,1);
    trap_ill = ov(0,0,0,0,0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 1,0,1);
    mem_addr = ov(0,0,0,0,0,0,0,1, 2'b10, 2'b00, 0, 2'b00, 0,0,0);
    alu_wb   = ov(0,0,0,0,0,0,0,0, 2'b00, 2'b00, 1, 2'b00, 0,0,1);

    // Fetch: opcode is don't-care until DECODE, so drive noise on it.
    mem_phase(ov(1,0,0,0,0,0,0,0, 2'b01, 2'b00, 0, 2'b00, 0,0,0),
              ov(0,0,0,1,1,0,0,0, 2'b00, 2'b00, 0, 2'b00, 0,0,0),
              wf, tmo, 7'($urandom), to);
    if (to) begin
      push(1'b0, op, trap_tmo);
      return;
    end
    push(1'b0, op, ov(0,0,0,0,0,0,0,0, 2'b10, 2'b00, 0, 2'b00, 0,0,0));

    case (op)
      7'b0110011: begin
        push(1'b0, op, ov(0,0,0,0,0,0,0,1, 2'b00, 2'b10, 0, 2'b00, 0,0,0));
        push(1'b0, op, alu_wb);
      end
      7'b0010011: begin
        push(1'b0, op, ov(0,0,0,0,0,0,0,1, 2'b10, 2'b11, 0, 2'b00, 0,0,0));
        push(1'b0, op, alu_wb);
      end
      7'b0000011: begin
        push(1'b0, op, mem_addr);
        mem_phase(ov(1,0,1,0,0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 0,0,0), 18'h0,
                  wm, tmo, op, to);
        if (to) push(1'b0, op, trap_tmo);
        else    push(1'b0, op, ov(0,0,0,0,0,0,0,0, 2'b00, 2'b00, 1, 2'b01, 0,0,1));
      end
      7'b0100011: begin
        push(1'b0, op, mem_addr);
        mem_phase(ov(1,1,1,0,0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 0,0,0),
                  ov(0,0,0,0,0,0,0,0, 2'b00, 2'b00, 0, 2'b00, 0,0,1),
                  wm, tmo, op, to);
        if (to) push(1'b0, op, trap_tmo);
      end
      7'b1100011: push(1'b0, op, ov(0,0,0,0,0,1,1,1, 2'b00, 2'b01, 0, 2'b00, 0,0,1));
      7'b1101111: begin
        if (jal_en) push(1'b0, op, ov(0,0,0,0,1,0,1,0, 2'b00, 2'b00, 1, 2'b10, 0,0,1));
        else        push(1'b0, op, trap_ill);
      end
      default:    push(1'b0, op, trap_ill);
    endcase
  endtask

  // Called at a falling edge: drive, let combinational outputs settle, compare,
  // then move to the next falling edge.
  task automatic step(input int d, input logic rdy, input logic [6:0] opc,
                      input logic [17:0] exp, input string tag);
    mem_ready_s[d] = rdy;
    opcode_s[d]    = opc;
    zero_s[d]      = 1'($urandom);
    #1;
    check_eq(tag, outv[d], exp);
    @(negedge clk);
  endtask

  task automatic run_sched(input int d, input int limit, input string name);
    int n;
    n = (limit < sched.size()) ? limit : sched.size();
    for (int i = 0; i < n; i++) begin
      step(d, sched[i].rdy, sched[i].opc, sched[i].exp, $sformatf("%s_c%0d", name, i));
    end
  endtask

  task automatic run_instr(input int d, input logic [6:0] op, input int wf, input int wm);
    string name;
    sched.delete();
    build(d, op, wf, wm);
    name = $sformatf("d%0d_op%07b_wf%0d_wm%0d", d, op, wf, wm);
    $display("instr %s cycles=%0d", name, sched.size());
    run_sched(d, sched.size(), name);
  endtask

  task automatic do_reset(input int d, input string tag);
    logic [17:0] fetch_vals;
    fetch_vals     = ov(1,0,0,0,0,0,0,0, 2'b01, 2'b00, 0, 2'b00, 0,0,0);
    mem_ready_s[d] = 1'b0;
    rst_n          = 1'b0;
    #1;
    check_eq({tag, "_async"}, outv[d], fetch_vals);
    @(negedge clk);
    #1;
    check_eq({tag, "_held"}, outv[d], fetch_vals);
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset %s dut=%0d", tag, d);
  endtask

  function automatic int pick_wait(input int tmo);
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 6) return 0;
    if (r < 8) return int'($urandom_range(1, 2));
    if (r == 8) return tmo - 1;
    return tmo + int'($urandom_range(0, 1));
  endfunction

  task automatic run_random(input int d, input int n);
    int tmo;
    tmo = (d == 0) ? 3 : 15;
    for (int k = 0; k < n; k++) begin
      logic [6:0] op;
      case ($urandom_range(0, 7))
        0:       op = 7'b0000011;
        1:       op = 7'b0100011;
        2:       op = 7'b0110011;
        3:       op = 7'b0010011;
        4:       op = 7'b1100011;
        5:       op = 7'b1101111;
        6:       op = 7'($urandom);
        default: op = 7'b0110011;
      endcase
      run_instr(d, op, pick_wait(tmo), pick_wait(tmo));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      opcode_s[i]    = 7'h0;
      zero_s[i]      = 1'b0;
      mem_ready_s[i] = 1'b0;
    end
    @(negedge clk);

    // ---- d0: MEM_TIMEOUT = 3, JAL enabled ----
    do_reset(0, "rst_d0");
    run_instr(0, 7'b0110011, 0, 0);   // R-type, 4 cycles
    run_instr(0, 7'b0010011, 0, 0);   // I-type, 4 cycles
    run_instr(0, 7'b0000011, 2, 2);   // LW with waits, 9 cycles
    run_instr(0, 7'b0100011, 0, 0);   // SW, 4 cycles
    run_instr(0, 7'b1100011, 0, 0);   // BEQ
    run_instr(0, 7'b1100011, 0, 0);   // BEQ again (different zero)
    run_instr(0, 7'b1101111, 0, 0);   // JAL executed
    run_instr(0, 7'b0100011, 0, 3);   // SW watchdog abort
    run_instr(0, 7'b0000011, 0, 2);   // ready in the expiry cycle
    run_instr(0, 7'b0110011, 3, 0);   // fetch watchdog abort
    run_instr(0, 7'b0000000, 0, 0);   // illegal opcode
    run_random(0, 80);

    // ---- d1: MEM_TIMEOUT = 15, JAL disabled ----
    do_reset(1, "rst_d1");
    run_instr(1, 7'b1101111, 0, 0);   // JAL trapped as illegal
    run_instr(1, 7'b0100011, 0, 14);  // ready in the expiry cycle
    run_instr(1, 7'b0000011, 1, 15);  // LW watchdog abort
    // Reset while a store is waiting in MEM_WR
    sched.delete();
    build(1, 7'b0100011, 0, 10);
    run_sched(1, 5, "d1_sw_pre_reset");
    do_reset(1, "rst_mid_memwr");
    run_random(1, 50);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
